// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_ctrl
// Description : Iterative multiply/divide sequencer beside the EX stage.
//               Accepts MULT/MULTU/DIV/DIVU with forwarded operands. It runs
//               a WIDTH-step shift-add multiply or restoring divide on operand
//               magnitudes, applies a sign fixup, and owns the HI/LO registers.
//               The front of the pipe is stalled while an operation is in flight.
// Ports       : clk    - rising-edge clock
//               reset  - asynchronous active-low reset
//               start  - EX holds a mul/div instruction (held while stalled)
//               op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               opa    - rs operand (dividend / multiplicand)
//               opb    - rt operand (divisor / multiplier)
//               flush  - kill the in-flight operation
//               hi_we  - MTHI write strobe (IDLE, start=0 only)
//               lo_we  - MTLO write strobe (IDLE, start=0 only)
//               wdata  - MTHI/MTLO data
//               stall  - freeze PC, IF/ID and ID/EX
//               done   - one-cycle pulse, HI/LO hold the new result
//               hi, lo - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;    // mul: {partial, multiplier}; div: {rem, quot}
    logic [WIDTH-1:0]     dvs_q;    // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]     opa_q;    // original dividend, needed for divide-by-zero
    logic                 is_div_q;
    logic                 neg_q;    // product / quotient negated
    logic                 rneg_q;   // remainder takes dividend sign
    logic                 divz_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 w_accept;
    logic                 w_sign_a, w_sign_b;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_sh;
    logic                 w_div_ok;
    logic [WIDTH-1:0]     w_div_sub;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot, w_rem;

    assign w_accept = (state_q == S_IDLE) && start && !flush;

    // op[0]=0 selects the signed variants
    assign w_sign_a = ~op[0] & opa[WIDTH-1];
    assign w_sign_b = ~op[0] & opb[WIDTH-1];
    // Negating 0x80..0 yields 2^(WIDTH-1) read as unsigned, which is exact
    assign w_mag_a  = w_sign_a ? (WIDTH'(0) - opa) : opa;
    assign w_mag_b  = w_sign_b ? (WIDTH'(0) - opb) : opb;

    // Shift-add step: the add may carry out, so the carry shifts into the top bit
    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: the shifted remainder is below 2*divisor, so WIDTH+1 bits
    // compare exactly and a kept difference always fits in WIDTH bits.
    assign w_div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign w_div_ok   = (w_div_sh >= {1'b0, dvs_q});
    assign w_div_sub  = w_div_sh[WIDTH-1:0] - dvs_q;
    assign w_div_next = {(w_div_ok ? w_div_sub : w_div_sh[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], w_div_ok};

    assign w_prod = neg_q  ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    assign w_quot = neg_q  ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign w_rem  = rneg_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = S_CALC;
                    stall   = reset;    // no stall while reset is asserted
                end
            end
            S_CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                stall   = 1'b1;
                state_d = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            opa_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        cnt_q    <= '0;
                        opa_q    <= opa;
                        is_div_q <= op[1];
                        neg_q    <= w_sign_a ^ w_sign_b;
                        rneg_q   <= w_sign_a;
                        divz_q   <= (opb == '0);
                        if (op[1]) begin
                            acc_q <= {{WIDTH{1'b0}}, w_mag_a};
                            dvs_q <= w_mag_b;
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, w_mag_b};
                            dvs_q <= w_mag_a;
                        end
                    end else if (!start) begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                S_CALC: begin
                    acc_q <= is_div_q ? w_div_next : w_mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_SIGN: begin
                    if (!flush) begin
                        if (!is_div_q) begin
                            hi_q <= w_prod[2*WIDTH-1:WIDTH];
                            lo_q <= w_prod[WIDTH-1:0];
                        end else if (divz_q) begin
                            hi_q <= opa_q;
                            lo_q <= {WIDTH{1'b1}};
                        end else begin
                            hi_q <= w_rem;
                            lo_q <= w_quot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_ctrl
// Description : Self-checking bench for ex_muldiv_ctrl. Expected HI/LO values
//               come from a behavioural arithmetic model, are queued when an
//               op is started and are popped when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa, opb, wdata;
    logic        flush, hi_we, lo_we;
    wire         stall, done;
    wire  [31:0] hi, lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            2'b00: begin p = sa * sb; r = p; end
            2'b01: r = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) check_eq({tag, "/queue"}, 64'd0, 64'd1);
        else check_eq(tag, {hi, lo}, exp_q.pop_front());
    endtask

    // Drive one op with start held until done; check latency, stall length and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc, nstall;
        bit seen;
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        exp_q.push_back(model(o, a, b));
        cyc = 0; nstall = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            #1;
            if (done) seen = 1'b1;
            else begin
                if (stall) nstall++;
                cyc++;
                @(negedge clk);
            end
        end
        check_eq({tag, "/seen_done"}, 64'(seen), 64'd1);
        if (seen) begin
            check_eq({tag, "/done_cyc"}, 64'(cyc), 64'd34);
            check_eq({tag, "/stall_cycles"}, 64'(nstall), 64'd34);
            check_eq({tag, "/stall_at_done"}, 64'(stall), 64'd0);
            pop_check({tag, "/hilo"});
        end else begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq({tag, "/done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  cyc, dones, first, guard;
        bit  saw;
        reset = 1'b0; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        repeat (3) @(negedge clk);
        #1;
        check_eq("reset/hilo", {hi, lo}, 64'd0);
        check_eq("reset/stall", 64'(stall), 64'd0);
        check_eq("reset/done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, "mult_7_m3");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
        run_op(2'b11, 32'h1234, 32'd0, "divu_by0");
        run_op(2'b10, 32'hFFFF_FF00, 32'd0, "div_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        for (int i = 0; i < 4; i++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom, $sformatf("rand%0d", i));
        end

        // MTHI / MTLO writes in IDLE
        @(negedge clk); hi_we = 1'b1; wdata = 32'hAA;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk); lo_we = 1'b0;
        #1;
        check_eq("mt/hilo", {hi, lo}, {32'hAA, 32'h55});

        // Flush at CALC counter 10: no done, HI/LO untouched
        @(negedge clk); op = 2'b00; opa = 32'd7; opb = 32'd3; start = 1'b1;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; start = 1'b0;
        #1;
        check_eq("flush/stall_next", 64'(stall), 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk); #1;
            if (done || stall) saw = 1'b1;
        end
        check_eq("flush/no_done", 64'(saw), 64'd0);
        check_eq("flush/hilo", {hi, lo}, {32'hAA, 32'h55});

        // Flush while start in IDLE: not accepted
        @(negedge clk); start = 1'b1; flush = 1'b1; #1;
        check_eq("idle_flush/stall", 64'(stall), 64'd0);
        @(negedge clk); start = 1'b0; flush = 1'b0; #1;
        check_eq("idle_flush/not_acc", 64'(stall), 64'd0);

        // start and hi_we together: start wins, write dropped
        @(negedge clk); op = 2'b01; opa = 32'd2; opb = 32'd3; start = 1'b1;
        hi_we = 1'b1; wdata = 32'h1234;
        exp_q.push_back(model(2'b01, 32'd2, 32'd3));
        @(negedge clk); hi_we = 1'b0; #1;
        check_eq("start_vs_we/hi", 64'(hi), 64'hAA);
        guard = 0;
        while (!done && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        check_eq("start_vs_we/seen_done", 64'(done), 64'd1);
        pop_check("start_vs_we/hilo");
        @(negedge clk); start = 1'b0;

        // Back-to-back MULTs with start held
        @(negedge clk); op = 2'b00; opa = 32'd5; opb = 32'hFFFF_FFFA; start = 1'b1;
        exp_q.push_back(model(2'b00, 32'd5, 32'hFFFF_FFFA));
        exp_q.push_back(model(2'b00, 32'd5, 32'hFFFF_FFFA));
        cyc = 0; dones = 0; first = -1;
        while (dones < 2 && cyc < 200) begin
            #1;
            if (done) begin
                pop_check($sformatf("b2b/hilo%0d", dones));
                if (dones == 0) first = cyc;
                else check_eq("b2b/gap", 64'(cyc - first), 64'd35);
                dones++;
            end
            if (dones < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("b2b/dones", 64'(dones), 64'd2);
        @(negedge clk); start = 1'b0; #1;
        check_eq("b2b/no_third", 64'(stall), 64'd0);
        while (exp_q.size() > 0) void'(exp_q.pop_front());

        // Reset at CALC counter 5
        @(negedge clk); op = 2'b00; opa = 32'd7; opb = 32'd3; start = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b0; #1;
        check_eq("rst_mid/hilo", {hi, lo}, 64'd0);
        check_eq("rst_mid/stall", 64'(stall), 64'd0);
        check_eq("rst_mid/done", 64'(done), 64'd0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); reset = 1'b1; #1;
        check_eq("rst_mid/stall_after", 64'(stall), 64'd0);

        // Sanity op after reset recovery
        run_op(2'b11, 32'd1000, 32'd33, "post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
